vga_sync_recover: RTL
=====================

# vga_sync_recover

Receive-side counterpart of the VGA sync decoder: takes active-low `h_sync`/`v_sync` (low only during retrace, 640x480 @ 800x525 total) and rebuilds the pixel coordinates that produced them. It regenerates `h_count`/`v_count`, `video_on` and a frame strobe, and reports lock status. It sits at the input of a capture or monitor path, or in a loopback bench checking the local timing generator.

## Interface
- `HD` 640, `HF` 16, `HB` 48, `HR` 96: horizontal display, front porch, back porch, retrace in pixels.
- `VD` 480, `VF` 10, `VB` 33, `VR` 2: vertical display, front porch, back porch, retrace in lines.
- `LOCK_FRAMES` 2: consecutive good frames needed to lock.
- `clk` input 1: pixel clock. Syncs are synchronous to it.
- `rst_n` input 1: asynchronous, active-low reset.
- `h_sync` input 1: horizontal sync, active low.
- `v_sync` input 1: vertical sync, active low.
- `h_count` output 10: recovered horizontal position, 0..HTOTAL-1.
- `v_count` output 10: recovered vertical position, 0..VTOTAL-1.
- `video_on` output 1: `locked && h_count<HD && v_count<VD`.
- `frame_start` output 1: one-cycle pulse when locked and `h_count==0 && v_count==0`.
- `locked` output 1: timing is verified.
- `sync_err` output 1: one-cycle pulse on loss of lock.

## Operation
- Derived constants: HTOTAL = HD+HF+HB+HR = 800; VTOTAL = VD+VF+VB+VR = 525.
- Each sync passes through one input register, then a fall detector: `fall = prev & ~cur`.
- Horizontal counter:
  - On `h_fall`, `h_count` loads HD+HF (656).
  - Otherwise it increments and wraps from HTOTAL-1 to 0.
- Vertical counter:
  - Increments when `h_count` wraps, and wraps from VTOTAL-1 to 0.
  - On `v_fall`, `v_count` loads VD+VF (490). This load takes priority over the increment.
- Line period counter `lp` (11 bits):
  - Clears to 0 on `h_fall`; otherwise increments, saturating at 2*HTOTAL.
  - A line is good when `lp==HTOTAL-1` at `h_fall`.
  - Reaching 2*HTOTAL is a timeout and counts as a bad line.
- Line counter `lc` (10 bits, saturating):
  - Increments on `h_fall` and clears on `v_fall`.
  - A frame is good when `lc==VTOTAL` at `v_fall` and no bad line occurred since the previous `v_fall`.
- When `h_fall` and `v_fall` occur in the same cycle, that line counts in the frame being closed. The line check is applied before the frame check.
- State machine (state and `gf`, the good-frame count, 2 bits):
  - SEARCH → ACQ on the first `v_fall`; `gf` = 0.
  - ACQ:
    - A bad line or bad frame sets `gf` to 0 and stays in ACQ.
    - A timeout returns to SEARCH.
    - A good frame increments `gf`; when `gf` reaches LOCK_FRAMES the state moves to LOCKED.
  - LOCKED: a bad line, bad frame or timeout returns to SEARCH and pulses `sync_err`.
- `locked` is 1 only in LOCKED. Counters free-run in all states; `video_on` and `frame_start` are gated by `locked`.
- Reset mid-operation: all state clears immediately; re-acquisition starts from SEARCH.

## Timing
- Reset values: `h_count`=0, `v_count`=0, `video_on`=0, `frame_start`=0, `locked`=0, `sync_err`=0. The fall detector's previous-sample register and the input register reset to 1 (idle), so no false edge follows reset.
- Latency: 2 cycles.
  - A source sync fall in cycle t is detected in cycle t+1.
  - In cycle t+2, `h_count`=656 (or `v_count`=490).
  - Once locked, `h_count`/`v_count` equal the source counters delayed by 2 cycles.
- All outputs are registered. `video_on` and `frame_start` are computed from next-state counter values, so they align with the registered counts.
- `locked` rises in the cycle after the `v_fall` that completes the LOCK_FRAMES-th good frame.
- `sync_err` and the fall of `locked` occur in the same cycle, one cycle after the failing detection.

## Structure
- Package `vga_timing_pkg`:
  - Timing localparams HD..VR, HTOTAL and VTOTAL, shared with the existing sync decoder.
  - State enum SEARCH/ACQ/LOCKED.
- Sub-module `sync_edge_det`: input register plus previous-sample register and fall pulse, reset to idle-high. Instantiated once for `h_sync` and once for `v_sync`.

## Test plan
- Reset, then hold syncs high: all outputs stay 0; no `sync_err`; state stays SEARCH.
- Clean 800x525 stream starting mid-frame: `locked` rises exactly one cycle after the third detected `v_fall`. Afterwards `h_count`==656 two cycles after every source `h_sync` fall, and `frame_start` pulses once per 420000 cycles.
- While locked, shorten one line to 799 cycles: at that line's `h_fall`, one `sync_err` pulse, `locked` drops to 0, and the next `v_fall` enters ACQ.
- While locked, stop `h_sync` toggling: `sync_err` pulses and `locked` drops when `lp` reaches 1600.
- Frame with 524 lines in ACQ: `gf` returns to 0; lock takes 2 further good frames.
- Assert `rst_n` low mid-line while locked: all outputs go to 0 asynchronously. After release, re-lock after 3 `v_fall`s.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// VGA 640x480 timing constants and the sync-recovery lock states.
// The sync decoder and the recovery block both use these definitions.
package vga_timing_pkg;

    localparam int unsigned HD = 640;
    localparam int unsigned HF = 16;
    localparam int unsigned HB = 48;
    localparam int unsigned HR = 96;
    localparam int unsigned VD = 480;
    localparam int unsigned VF = 10;
    localparam int unsigned VB = 33;
    localparam int unsigned VR = 2;

    localparam int unsigned HTOTAL = HD + HF + HB + HR;
    localparam int unsigned VTOTAL = VD + VF + VB + VR;

    localparam int unsigned LOCK_FRAMES = 2;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } sync_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Registers an active-low sync and flags its falling edge.
// Both stages reset high, so leaving reset never produces a false edge.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sync,
    output logic fall
);

    logic cur;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur  <= 1'b1;
            prev <= 1'b1;
        end else begin
            cur  <= sync;
            prev <= cur;
        end
    end

    assign fall = prev & ~cur;

endmodule

// File: rtl/vga_sync_recover.sv
// Rebuilds pixel coordinates from incoming active-low VGA syncs and
// tracks whether the line and frame timing is trustworthy.
module vga_sync_recover #(
    parameter int unsigned HD          = vga_timing_pkg::HD,
    parameter int unsigned HF          = vga_timing_pkg::HF,
    parameter int unsigned HB          = vga_timing_pkg::HB,
    parameter int unsigned HR          = vga_timing_pkg::HR,
    parameter int unsigned VD          = vga_timing_pkg::VD,
    parameter int unsigned VF          = vga_timing_pkg::VF,
    parameter int unsigned VB          = vga_timing_pkg::VB,
    parameter int unsigned VR          = vga_timing_pkg::VR,
    parameter int unsigned LOCK_FRAMES = vga_timing_pkg::LOCK_FRAMES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       h_sync,
    input  logic       v_sync,
    output logic [9:0] h_count,
    output logic [9:0] v_count,
    output logic       video_on,
    output logic       frame_start,
    output logic       locked,
    output logic       sync_err
);

    import vga_timing_pkg::sync_state_t;
    import vga_timing_pkg::SEARCH;
    import vga_timing_pkg::ACQ;
    import vga_timing_pkg::LOCKED;

    localparam int unsigned HTOTAL = HD + HF + HB + HR;
    localparam int unsigned VTOTAL = VD + VF + VB + VR;

    localparam logic [9:0]  H_DISP  = 10'(HD);
    localparam logic [9:0]  V_DISP  = 10'(VD);
    localparam logic [9:0]  H_LOAD  = 10'(HD + HF);
    localparam logic [9:0]  V_LOAD  = 10'(VD + VF);
    localparam logic [9:0]  H_LAST  = 10'(HTOTAL - 1);
    localparam logic [9:0]  V_LAST  = 10'(VTOTAL - 1);
    localparam logic [10:0] LP_GOOD = 11'(HTOTAL - 1);
    localparam logic [10:0] LP_SAT  = 11'(2 * HTOTAL);
    localparam logic [9:0]  LC_GOOD = 10'(VTOTAL);
    localparam logic [1:0]  GF_LOCK = 2'(LOCK_FRAMES);

    logic        h_fall, v_fall;
    logic [9:0]  h_next, v_next;
    logic [10:0] lp, lp_next;
    logic [9:0]  lc, lc_inc, lc_next;
    logic        bad_seen, bad_acc, bad_next;
    logic        timeout, line_bad, frame_good;
    sync_state_t state, state_next;
    logic [1:0]  gf, gf_next;
    logic        err_next;
    logic        lock_next;

    sync_edge_det u_h_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .sync  (h_sync),
        .fall  (h_fall)
    );

    sync_edge_det u_v_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .sync  (v_sync),
        .fall  (v_fall)
    );

    always_comb begin
        h_next = (h_count == H_LAST) ? '0 : h_count + 10'd1;
        if (h_fall) h_next = H_LOAD;

        v_next = v_count;
        if (!h_fall && h_count == H_LAST) v_next = (v_count == V_LAST) ? '0 : v_count + 10'd1;
        if (v_fall) v_next = V_LOAD;

        lp_next = (lp == LP_SAT) ? lp : lp + 11'd1;
        if (h_fall) lp_next = '0;
        timeout  = (lp == LP_SAT);
        line_bad = (h_fall && lp != LP_GOOD) || timeout;

        // A line ending together with v_fall still belongs to the closing frame.
        lc_inc     = (h_fall && lc != '1) ? lc + 10'd1 : lc;
        bad_acc    = bad_seen | line_bad;
        frame_good = (lc_inc == LC_GOOD) && !bad_acc;
        lc_next    = v_fall ? '0 : lc_inc;
        bad_next   = v_fall ? 1'b0 : bad_acc;
    end

    always_comb begin
        state_next = state;
        gf_next    = gf;
        err_next   = 1'b0;
        case (state)
            SEARCH: begin
                if (v_fall) begin
                    state_next = ACQ;
                    gf_next    = '0;
                end
            end
            ACQ: begin
                if (timeout) begin
                    state_next = SEARCH;
                    gf_next    = '0;
                end else if (line_bad || (v_fall && !frame_good)) begin
                    gf_next = '0;
                end else if (v_fall) begin
                    gf_next = gf + 2'd1;
                    if (gf_next >= GF_LOCK) state_next = LOCKED;
                end
            end
            LOCKED: begin
                if (line_bad || (v_fall && !frame_good)) begin
                    state_next = SEARCH;
                    err_next   = 1'b1;
                end
            end
            default: state_next = SEARCH;
        endcase
        lock_next = (state_next == LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_count     <= '0;
            v_count     <= '0;
            lp          <= '0;
            lc          <= '0;
            bad_seen    <= 1'b0;
            state       <= SEARCH;
            gf          <= '0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            h_count     <= h_next;
            v_count     <= v_next;
            lp          <= lp_next;
            lc          <= lc_next;
            bad_seen    <= bad_next;
            state       <= state_next;
            gf          <= gf_next;
            locked      <= lock_next;
            sync_err    <= err_next;
            video_on    <= lock_next && (h_next < H_DISP) && (v_next < V_DISP);
            frame_start <= lock_next && (h_next == '0) && (v_next == '0);
        end
    end

endmodule
